// File: rtl/sm4_pkg.sv
// SM4 shared definitions: S-box table, byte substitution and the two linear transforms (L, L').
package sm4_pkg;

    typedef logic [31:0] sm4_word_t;

    localparam logic [7:0] SM4_SBOX [256] = '{
        8'hD6, 8'h90, 8'hE9, 8'hFE, 8'hCC, 8'hE1, 8'h3D, 8'hB7, 8'h16, 8'hB6, 8'h14, 8'hC2, 8'h28, 8'hFB, 8'h2C, 8'h05,
        8'h2B, 8'h67, 8'h9A, 8'h76, 8'h2A, 8'hBE, 8'h04, 8'hC3, 8'hAA, 8'h44, 8'h13, 8'h26, 8'h49, 8'h86, 8'h06, 8'h99,
        8'h9C, 8'h42, 8'h50, 8'hF4, 8'h91, 8'hEF, 8'h98, 8'h7A, 8'h33, 8'h54, 8'h0B, 8'h43, 8'hED, 8'hCF, 8'hAC, 8'h62,
        8'hE4, 8'hB3, 8'h1C, 8'hA9, 8'hC9, 8'h08, 8'hE8, 8'h95, 8'h80, 8'hDF, 8'h94, 8'hFA, 8'h75, 8'h8F, 8'h3F, 8'hA6,
        8'h47, 8'h07, 8'hA7, 8'hFC, 8'hF3, 8'h73, 8'h17, 8'hBA, 8'h83, 8'h59, 8'h3C, 8'h19, 8'hE6, 8'h85, 8'h4F, 8'hA8,
        8'h68, 8'h6B, 8'h81, 8'hB2, 8'h71, 8'h64, 8'hDA, 8'h8B, 8'hF8, 8'hEB, 8'h0F, 8'h4B, 8'h70, 8'h56, 8'h9D, 8'h35,
        8'h1E, 8'h24, 8'h0E, 8'h5E, 8'h63, 8'h58, 8'hD1, 8'hA2, 8'h25, 8'h22, 8'h7C, 8'h3B, 8'h01, 8'h21, 8'h78, 8'h87,
        8'hD4, 8'h00, 8'h46, 8'h57, 8'h9F, 8'hD3, 8'h27, 8'h52, 8'h4C, 8'h36, 8'h02, 8'hE7, 8'hA0, 8'hC4, 8'hC8, 8'h9E,
        8'hEA, 8'hBF, 8'h8A, 8'hD2, 8'h40, 8'hC7, 8'h38, 8'hB5, 8'hA3, 8'hF7, 8'hF2, 8'hCE, 8'hF9, 8'h61, 8'h15, 8'hA1,
        8'hE0, 8'hAE, 8'h5D, 8'hA4, 8'h9B, 8'h34, 8'h1A, 8'h55, 8'hAD, 8'h93, 8'h32, 8'h30, 8'hF5, 8'h8C, 8'hB1, 8'hE3,
        8'h1D, 8'hF6, 8'hE2, 8'h2E, 8'h82, 8'h66, 8'hCA, 8'h60, 8'hC0, 8'h29, 8'h23, 8'hAB, 8'h0D, 8'h53, 8'h4E, 8'h6F,
        8'hD5, 8'hDB, 8'h37, 8'h45, 8'hDE, 8'hFD, 8'h8E, 8'h2F, 8'h03, 8'hFF, 8'h6A, 8'h72, 8'h6D, 8'h6C, 8'h5B, 8'h51,
        8'h8D, 8'h1B, 8'hAF, 8'h92, 8'hBB, 8'hDD, 8'hBC, 8'h7F, 8'h11, 8'hD9, 8'h5C, 8'h41, 8'h1F, 8'h10, 8'h5A, 8'hD8,
        8'h0A, 8'hC1, 8'h31, 8'h88, 8'hA5, 8'hCD, 8'h7B, 8'hBD, 8'h2D, 8'h74, 8'hD0, 8'h12, 8'hB8, 8'hE5, 8'hB4, 8'hB0,
        8'h89, 8'h69, 8'h97, 8'h4A, 8'h0C, 8'h96, 8'h77, 8'h7E, 8'h65, 8'hB9, 8'hF1, 8'h09, 8'hC5, 8'h6E, 8'hC6, 8'h84,
        8'h18, 8'hF0, 8'h7D, 8'hEC, 8'h3A, 8'hDC, 8'h4D, 8'h20, 8'h79, 8'hEE, 8'h5F, 8'h3E, 8'hD7, 8'hCB, 8'h39, 8'h48
    };

    function automatic logic [7:0] sm4_sbox8(input logic [7:0] x);
        return SM4_SBOX[x];
    endfunction

    // Rotations written as concatenations so each transform is a flat XOR tree.
    function automatic sm4_word_t sm4_l(input sm4_word_t b);
        return b ^ {b[29:0], b[31:30]} ^ {b[21:0], b[31:22]}
                 ^ {b[13:0], b[31:14]} ^ {b[7:0], b[31:8]};
    endfunction

    function automatic sm4_word_t sm4_lprime(input sm4_word_t b);
        return b ^ {b[18:0], b[31:19]} ^ {b[8:0], b[31:9]};
    endfunction

endpackage

// File: rtl/sm4_sbox_lut.sv
// One combinational SM4 byte substitution lane.
module sm4_sbox_lut
    import sm4_pkg::*;
(
    input  logic [7:0] byte_i,
    output logic [7:0] byte_o
);

    assign byte_o = sm4_sbox8(byte_i);

endmodule

// File: rtl/sm4_sbox_pipe.sv
// Pipelined multi-lane SM4 tau engine with valid/ready, flush and tag pass-through.
// Optional macro SM4_SBOX_LXFORM_EN adds the per-word L / L' transform after the last stage.
module sm4_sbox_pipe
    import sm4_pkg::*;
#(
    parameter int NUM_WORDS  = 1,
    parameter int PIPE_DEPTH = 2,
    parameter int TAG_W      = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   flush_i,
    input  logic                   in_valid_i,
    output logic                   in_ready_o,
    input  logic [32*NUM_WORDS-1:0] in_data_i,
    input  logic [TAG_W-1:0]       in_tag_i,
`ifdef SM4_SBOX_LXFORM_EN
    input  logic                   in_mode_i,
`endif
    output logic                   out_valid_o,
    input  logic                   out_ready_i,
    output logic [32*NUM_WORDS-1:0] out_data_o,
    output logic [TAG_W-1:0]       out_tag_o,
    output logic                   busy_o
);

    localparam int DW    = 32 * NUM_WORDS;
    localparam int LANES = 4 * NUM_WORDS;

    generate
        if (PIPE_DEPTH < 1 || PIPE_DEPTH > 4 || NUM_WORDS < 1) begin : g_bad_param
            $error("sm4_sbox_pipe: PIPE_DEPTH must be 1..4 and NUM_WORDS >= 1");
        end
    endgenerate

    logic [DW-1:0]         sbox_d;
    logic [PIPE_DEPTH-1:0] vld_p;
    logic [PIPE_DEPTH-1:0] can_load;
    logic [PIPE_DEPTH-1:0] move;
    logic [DW-1:0]         data_p [PIPE_DEPTH];
    logic [TAG_W-1:0]      tag_p  [PIPE_DEPTH];
`ifdef SM4_SBOX_LXFORM_EN
    logic [PIPE_DEPTH-1:0] mode_p;
`endif
    logic                  in_fire;

    // Input -> stage 0: byte substitution
    generate
        for (genvar k = 0; k < LANES; k++) begin : g_lane
            sm4_sbox_lut u_lut (
                .byte_i (in_data_i[8*k +: 8]),
                .byte_o (sbox_d[8*k +: 8])
            );
        end
    endgenerate

    // A stage can take a new beat when some stage at or after it is empty, or the tail drains.
    always_comb begin
        can_load = '0;
        move     = '0;
        for (int s = 0; s < PIPE_DEPTH; s++) begin
            can_load[s] = out_ready_i;
            for (int j = s; j < PIPE_DEPTH; j++) begin
                if (!vld_p[j]) can_load[s] = 1'b1;
            end
        end
        for (int s = 0; s < PIPE_DEPTH - 1; s++) begin
            move[s] = vld_p[s] & can_load[s+1];
        end
        move[PIPE_DEPTH-1] = vld_p[PIPE_DEPTH-1] & out_ready_i;
    end

    assign in_ready_o = can_load[0] & ~flush_i & ~rst_i;
    assign in_fire    = in_valid_i & in_ready_o;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            vld_p <= '0;
            for (int s = 0; s < PIPE_DEPTH; s++) begin
                data_p[s] <= '0;
                tag_p[s]  <= '0;
            end
`ifdef SM4_SBOX_LXFORM_EN
            mode_p <= '0;
`endif
        end else begin
            // Stage 0 capture
            if (can_load[0]) begin
                vld_p[0] <= in_fire;
                if (in_fire) begin
                    data_p[0] <= sbox_d;
                    tag_p[0]  <= in_tag_i;
`ifdef SM4_SBOX_LXFORM_EN
                    mode_p[0] <= in_mode_i;
`endif
                end
            end
            // Stage s-1 -> stage s: plain registers
            for (int s = 1; s < PIPE_DEPTH; s++) begin
                if (can_load[s]) begin
                    vld_p[s] <= move[s-1];
                    if (move[s-1]) begin
                        data_p[s] <= data_p[s-1];
                        tag_p[s]  <= tag_p[s-1];
`ifdef SM4_SBOX_LXFORM_EN
                        mode_p[s] <= mode_p[s-1];
`endif
                    end
                end
            end
            if (flush_i) vld_p <= '0;
        end
    end

    // Last stage -> output
    assign out_valid_o = vld_p[PIPE_DEPTH-1];
    assign out_tag_o   = tag_p[PIPE_DEPTH-1];
    assign busy_o      = |vld_p;

`ifdef SM4_SBOX_LXFORM_EN
    always_comb begin
        out_data_o = '0;
        for (int w = 0; w < NUM_WORDS; w++) begin
            out_data_o[32*w +: 32] = mode_p[PIPE_DEPTH-1] ? sm4_lprime(data_p[PIPE_DEPTH-1][32*w +: 32])
                                                          : sm4_l(data_p[PIPE_DEPTH-1][32*w +: 32]);
        end
    end
`else
    assign out_data_o = data_p[PIPE_DEPTH-1];
`endif

endmodule

// File: tb/tb_sm4_sbox_pipe.sv
// Self-checking bench for sm4_sbox_pipe (NUM_WORDS=1, PIPE_DEPTH=2) against a queue-based reference.
module tb_sm4_sbox_pipe;

    localparam int NW = 1;
    localparam int PD = 2;
    localparam int TW = 4;

    logic            clk = 1'b0;
    logic            rst_i, flush_i, in_valid_i, in_ready_o, out_valid_o, out_ready_i, busy_o;
    logic [31:0]     in_data_i, out_data_o;
    logic [TW-1:0]   in_tag_i, out_tag_o;
    logic            in_mode = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;
    int out_count;
    int accepted;
    bit last_in_fire;

    typedef struct {
        logic [31:0]   d;
        logic [TW-1:0] t;
    } beat_t;
    beat_t exp_q[$];

    logic [7:0] ref_sbox [256] = '{
        8'hD6, 8'h90, 8'hE9, 8'hFE, 8'hCC, 8'hE1, 8'h3D, 8'hB7, 8'h16, 8'hB6, 8'h14, 8'hC2, 8'h28, 8'hFB, 8'h2C, 8'h05,
        8'h2B, 8'h67, 8'h9A, 8'h76, 8'h2A, 8'hBE, 8'h04, 8'hC3, 8'hAA, 8'h44, 8'h13, 8'h26, 8'h49, 8'h86, 8'h06, 8'h99,
        8'h9C, 8'h42, 8'h50, 8'hF4, 8'h91, 8'hEF, 8'h98, 8'h7A, 8'h33, 8'h54, 8'h0B, 8'h43, 8'hED, 8'hCF, 8'hAC, 8'h62,
        8'hE4, 8'hB3, 8'h1C, 8'hA9, 8'hC9, 8'h08, 8'hE8, 8'h95, 8'h80, 8'hDF, 8'h94, 8'hFA, 8'h75, 8'h8F, 8'h3F, 8'hA6,
        8'h47, 8'h07, 8'hA7, 8'hFC, 8'hF3, 8'h73, 8'h17, 8'hBA, 8'h83, 8'h59, 8'h3C, 8'h19, 8'hE6, 8'h85, 8'h4F, 8'hA8,
        8'h68, 8'h6B, 8'h81, 8'hB2, 8'h71, 8'h64, 8'hDA, 8'h8B, 8'hF8, 8'hEB, 8'h0F, 8'h4B, 8'h70, 8'h56, 8'h9D, 8'h35,
        8'h1E, 8'h24, 8'h0E, 8'h5E, 8'h63, 8'h58, 8'hD1, 8'hA2, 8'h25, 8'h22, 8'h7C, 8'h3B, 8'h01, 8'h21, 8'h78, 8'h87,
        8'hD4, 8'h00, 8'h46, 8'h57, 8'h9F, 8'hD3, 8'h27, 8'h52, 8'h4C, 8'h36, 8'h02, 8'hE7, 8'hA0, 8'hC4, 8'hC8, 8'h9E,
        8'hEA, 8'hBF, 8'h8A, 8'hD2, 8'h40, 8'hC7, 8'h38, 8'hB5, 8'hA3, 8'hF7, 8'hF2, 8'hCE, 8'hF9, 8'h61, 8'h15, 8'hA1,
        8'hE0, 8'hAE, 8'h5D, 8'hA4, 8'h9B, 8'h34, 8'h1A, 8'h55, 8'hAD, 8'h93, 8'h32, 8'h30, 8'hF5, 8'h8C, 8'hB1, 8'hE3,
        8'h1D, 8'hF6, 8'hE2, 8'h2E, 8'h82, 8'h66, 8'hCA, 8'h60, 8'hC0, 8'h29, 8'h23, 8'hAB, 8'h0D, 8'h53, 8'h4E, 8'h6F,
        8'hD5, 8'hDB, 8'h37, 8'h45, 8'hDE, 8'hFD, 8'h8E, 8'h2F, 8'h03, 8'hFF, 8'h6A, 8'h72, 8'h6D, 8'h6C, 8'h5B, 8'h51,
        8'h8D, 8'h1B, 8'hAF, 8'h92, 8'hBB, 8'hDD, 8'hBC, 8'h7F, 8'h11, 8'hD9, 8'h5C, 8'h41, 8'h1F, 8'h10, 8'h5A, 8'hD8,
        8'h0A, 8'hC1, 8'h31, 8'h88, 8'hA5, 8'hCD, 8'h7B, 8'hBD, 8'h2D, 8'h74, 8'hD0, 8'h12, 8'hB8, 8'hE5, 8'hB4, 8'hB0,
        8'h89, 8'h69, 8'h97, 8'h4A, 8'h0C, 8'h96, 8'h77, 8'h7E, 8'h65, 8'hB9, 8'hF1, 8'h09, 8'hC5, 8'h6E, 8'hC6, 8'h84,
        8'h18, 8'hF0, 8'h7D, 8'hEC, 8'h3A, 8'hDC, 8'h4D, 8'h20, 8'h79, 8'hEE, 8'h5F, 8'h3E, 8'hD7, 8'hCB, 8'h39, 8'h48
    };

    sm4_sbox_pipe #(.NUM_WORDS(NW), .PIPE_DEPTH(PD), .TAG_W(TW)) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .flush_i     (flush_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .in_data_i   (in_data_i),
        .in_tag_i    (in_tag_i),
`ifdef SM4_SBOX_LXFORM_EN
        .in_mode_i   (in_mode),
`endif
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_data_o  (out_data_o),
        .out_tag_o   (out_tag_o),
        .busy_o      (busy_o)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rol(input logic [31:0] b, input int n);
        return (b << n) | (b >> (32 - n));
    endfunction

    // Reference: substitute each byte via the table, then optionally apply L or L'.
    function automatic logic [31:0] ref_out(input logic [31:0] x, input logic mode);
        logic [31:0] b;
        for (int k = 0; k < 4; k++) b[8*k +: 8] = ref_sbox[x[8*k +: 8]];
`ifdef SM4_SBOX_LXFORM_EN
        if (mode) b = b ^ rol(b, 13) ^ rol(b, 23);
        else      b = b ^ rol(b, 2) ^ rol(b, 10) ^ rol(b, 18) ^ rol(b, 24);
`else
        if (mode) b = b;
`endif
        return b;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock with the currently driven inputs; the model follows every handshake.
    task automatic cycle();
        #1;
        last_in_fire = in_valid_i && in_ready_o;
        if (out_valid_o) begin
            if (exp_q.size() == 0) begin
                check("spurious_out", {31'd0, out_valid_o}, 32'd0);
            end else begin
                check("out_data", out_data_o, exp_q[0].d);
                check("out_tag", {28'd0, out_tag_o}, {28'd0, exp_q[0].t});
                if (out_ready_i) begin
                    void'(exp_q.pop_front());
                    out_count++;
                end
            end
        end
        if (last_in_fire) begin
            exp_q.push_back('{d: ref_out(in_data_i, in_mode), t: in_tag_i});
            accepted++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        in_valid_i  = 1'b0;
        out_ready_i = 1'b1;
        for (int i = 0; i < 20 && (exp_q.size() != 0 || busy_o); i++) cycle();
        check("drain_empty", exp_q.size(), 32'd0);
        check("drain_busy", {31'd0, busy_o}, 32'd0);
    endtask

    initial begin
        int sent;
        int cyc;
        rst_i = 1'b1; flush_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b0;
        in_data_i = '0; in_tag_i = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", {31'd0, out_valid_o}, 32'd0);
        check("rst_busy", {31'd0, busy_o}, 32'd0);
        check("rst_out_data", out_data_o, 32'd0);
        check("rst_out_tag", {28'd0, out_tag_o}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready_o}, 32'd0);
        rst_i = 1'b0;
        #1;
        check("post_rst_in_ready", {31'd0, in_ready_o}, 32'd1);

        // Directed single beat, exact latency
        in_valid_i = 1'b1; in_data_i = 32'h00FFAB00; in_tag_i = 4'h5; out_ready_i = 1'b1;
        @(posedge clk); #1;
        in_valid_i = 1'b0;
        check("lat1_valid", {31'd0, out_valid_o}, 32'd0);
        @(posedge clk); #1;
        check("lat2_valid", {31'd0, out_valid_o}, 32'd1);
        check("lat2_data", out_data_o, 32'hD648ABD6);
        check("lat2_tag", {28'd0, out_tag_o}, 32'd5);
        @(posedge clk); #1;
        check("lat3_valid", {31'd0, out_valid_o}, 32'd0);

        // Random stream covering every byte value in lane 0, random backpressure
        sent = 0; out_count = 0; cyc = 0;
        while ((sent < 256 || exp_q.size() != 0) && cyc < 4000) begin
            in_valid_i  = (sent < 256) && ($urandom_range(0, 3) != 0);
            in_data_i   = {$urandom_range(0, 255) , 8'(sent), 8'(255 - sent), 8'(sent)};
            in_data_i[31:24] = 8'($urandom);
            in_tag_i    = 4'(sent);
            in_mode     = 1'($urandom);
            out_ready_i = 1'($urandom);
            cycle();
            if (last_in_fire) sent++;
            cyc++;
        end
        check("stream_pending", exp_q.size(), 32'd0);
        check("stream_count", out_count, 32'd256);
        drain();

        // Fill with stalled output, then release for full throughput
        out_ready_i = 1'b0; in_valid_i = 1'b1; accepted = 0;
        for (int i = 0; i < 6; i++) begin
            in_data_i = $urandom; in_tag_i = 4'(i);
            cycle();
        end
        check("fill_accepted", accepted, PD);
        check("fill_in_ready", {31'd0, in_ready_o}, 32'd0);
        out_ready_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_data_i = $urandom; in_tag_i = 4'(i + 6);
            cycle();
            check("rel_in_ready", {31'd0, in_ready_o}, 32'd1);
            check("rel_out_valid", {31'd0, out_valid_o}, 32'd1);
        end
        drain();

        // Flush with two beats in flight
        out_ready_i = 1'b0; in_valid_i = 1'b1;
        for (int i = 0; i < 2; i++) begin
            in_data_i = $urandom; in_tag_i = 4'(i);
            cycle();
        end
        flush_i = 1'b1;
        #1;
        check("flush_in_ready", {31'd0, in_ready_o}, 32'd0);
        @(posedge clk); #1;
        flush_i = 1'b0; in_valid_i = 1'b0;
        check("flush_out_valid", {31'd0, out_valid_o}, 32'd0);
        check("flush_busy", {31'd0, busy_o}, 32'd0);
        exp_q.delete();
        out_ready_i = 1'b1;
        repeat (5) cycle();

        // Reset with a stalled valid output
        out_ready_i = 1'b0; in_valid_i = 1'b1;
        for (int i = 0; i < PD + 1; i++) begin
            in_data_i = $urandom | 32'h1; in_tag_i = 4'hA;
            cycle();
        end
        in_valid_i = 1'b0;
        check("pre_rst_out_valid", {31'd0, out_valid_o}, 32'd1);
        rst_i = 1'b1;
        #1;
        check("rst_cycle_in_ready", {31'd0, in_ready_o}, 32'd0);
        @(posedge clk); #1;
        check("mid_rst_out_valid", {31'd0, out_valid_o}, 32'd0);
        check("mid_rst_out_data", out_data_o, 32'd0);
        check("mid_rst_out_tag", {28'd0, out_tag_o}, 32'd0);
        check("mid_rst_busy", {31'd0, busy_o}, 32'd0);
        rst_i = 1'b0;
        exp_q.delete();
        #1;
        check("mid_rst_in_ready", {31'd0, in_ready_o}, 32'd1);
        out_ready_i = 1'b1;
        repeat (4) cycle();

`ifdef SM4_SBOX_LXFORM_EN
        // Linear transform on all-zero input
        out_ready_i = 1'b1; in_valid_i = 1'b1; in_data_i = 32'h0; in_tag_i = 4'h1; in_mode = 1'b0;
        @(posedge clk); #1;
        in_tag_i = 4'h2; in_mode = 1'b1;
        @(posedge clk); #1;
        in_valid_i = 1'b0;
        check("lx_mode0", out_data_o, 32'h5B5B5B5B);
        @(posedge clk); #1;
        check("lx_mode1", out_data_o, 32'h67676767);
        drain();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
